// File: rtl/frv_dmem_arbiter.sv
// frv_dmem_arbiter: round-robin sharing of the data-memory port between two requesters
module frv_dmem_arbiter #(
  parameter int XLEN        = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            r0_req,
  input  logic            r0_wen,
  input  logic [3:0]      r0_strb,
  input  logic [XLEN-1:0] r0_wdata,
  input  logic [XLEN-1:0] r0_addr,
  output logic            r0_gnt,
  output logic            r0_recv,
  input  logic            r0_ack,
  output logic            r0_error,
  output logic [XLEN-1:0] r0_rdata,
  input  logic            r1_req,
  input  logic            r1_wen,
  input  logic [3:0]      r1_strb,
  input  logic [XLEN-1:0] r1_wdata,
  input  logic [XLEN-1:0] r1_addr,
  output logic            r1_gnt,
  output logic            r1_recv,
  input  logic            r1_ack,
  output logic            r1_error,
  output logic [XLEN-1:0] r1_rdata,
  output logic            m_req,
  output logic            m_wen,
  output logic [3:0]      m_strb,
  output logic [XLEN-1:0] m_wdata,
  output logic [XLEN-1:0] m_addr,
  input  logic            m_gnt,
  input  logic            m_recv,
  output logic            m_ack,
  input  logic            m_error,
  input  logic [XLEN-1:0] m_rdata,
  output logic            busy,
  output logic            spurious
);
  localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam logic [PW-1:0] PMAX = PW'(OUTSTANDING - 1);
  localparam logic [CW-1:0] CMAX = CW'(OUTSTANDING);
  logic [OUTSTANDING-1:0] own_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic last_q, lock_q, sel_q, spurious_q;
  logic sel, rsel_req, empty, full, owner, push, pop;
  // Arbitration, request mux, grant and response routing
  always_comb begin
    empty    = cnt_q == '0;
    full     = cnt_q == CMAX;
    sel      = lock_q ? sel_q : (r0_req && r1_req) ? !last_q : r1_req;
    rsel_req = sel ? r1_req : r0_req;
    m_req    = rsel_req && !full;
    m_wen    = sel ? r1_wen : r0_wen;
    m_strb   = sel ? r1_strb : r0_strb;
    m_wdata  = sel ? r1_wdata : r0_wdata;
    m_addr   = sel ? r1_addr : r0_addr;
    push     = m_req && m_gnt;
    r0_gnt   = push && !sel;
    r1_gnt   = push && sel;
    owner    = own_q[rptr_q];
    r0_recv  = m_recv && !empty && !owner;
    r1_recv  = m_recv && !empty && owner;
    r0_error = m_error && r0_recv;
    r1_error = m_error && r1_recv;
    m_ack    = empty ? m_recv : owner ? r1_ack : r0_ack;
    pop      = m_recv && m_ack && !empty;
  end
  assign r0_rdata = m_rdata;
  assign r1_rdata = m_rdata;
  assign busy     = !empty;
  assign spurious = spurious_q;
  // Owner FIFO, fairness pointer, request lock and sticky spurious flag
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      own_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      lock_q     <= 1'b0;
      sel_q      <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      if (push) begin
        own_q[wptr_q] <= sel;
        wptr_q        <= wptr_q == PMAX ? '0 : wptr_q + 1'b1;
        last_q        <= sel;
      end
      if (pop) rptr_q <= rptr_q == PMAX ? '0 : rptr_q + 1'b1;
      cnt_q      <= cnt_q + CW'(push) - CW'(pop);
      lock_q     <= m_req && !m_gnt;
      sel_q      <= sel;
      spurious_q <= spurious_q || (m_recv && empty);
    end
  end
endmodule

// File: doc/frv_dmem_arbiter.md
Name: frv_dmem_arbiter

Overview:
- Shares the single core data-memory port between two requesters: port 0 (pipeline LSU, memory stage) and port 1 (auxiliary master, e.g. debug/DMA).
- Request channel uses req/gnt with round-robin arbitration and a request lock.
- Response channel uses recv/ack; an owner-tracking FIFO routes each response back to the requester whose transaction it completes.
- Sits between the memory/writeback stages and the external dmem bus.

Parameters:
XLEN, 32, data/address width.
OUTSTANDING, 2, max granted-but-unresponded transactions (power of 2, >=1).

Ports:
g_clk  in  1  global clock
g_resetn  in  1  synchronous reset, active-low
rN_req  in  1  requester N request valid (N = 0,1; same set per port)
rN_wen  in  1  requester N write enable
rN_strb  in  4  requester N byte strobe
rN_wdata  in  XLEN  requester N write data
rN_addr  in  XLEN  requester N address
rN_gnt  out  1  request accepted for requester N
rN_recv  out  1  response valid to requester N
rN_ack  in  1  requester N accepts response
rN_error  out  1  response error to requester N
rN_rdata  out  XLEN  response read data to requester N
m_req  out  1  memory request
m_wen  out  1  memory write enable
m_strb  out  4  memory strobe
m_wdata  out  XLEN  memory write data
m_addr  out  XLEN  memory address
m_gnt  in  1  memory request accepted
m_recv  in  1  memory response valid
m_ack  out  1  response accepted
m_error  in  1  memory response error
m_rdata  in  XLEN  memory read data
busy  out  1  FIFO non-empty
spurious  out  1  sticky: response arrived with no outstanding transaction

Behaviour:
- Reset (g_resetn=0 at clock edge): FIFO empty, last=1 (port 0 wins first contest), lock=0, sel=0, spurious=0.
- All outputs are combinational from state and inputs; with no requests after reset, all outputs are 0 except rN_rdata, which mirrors m_rdata.
- Arbitration, when lock=0:
  - Only r0_req: sel=0. Only r1_req: sel=1.
  - Both: sel = !last.
  - Neither: m_req=0.
- Lock: set when m_req && !m_gnt, holding sel until m_gnt; this gives the request stability the dmem bus requires.
  - If the locked requester drops its req while locked, lock clears the next cycle. Requesters must not do this; a bench assertion flags it.
- m_req = rsel_req && !full. m_wen/m_strb/m_wdata/m_addr are muxed from sel.
- rsel_gnt = m_gnt && m_req. The non-selected gnt is 0. No grant is possible while full.
- On m_req && m_gnt: push sel into the FIFO, set last=sel, clear lock. Zero-latency: a grant is issued in the same cycle as the request.
- Response routing:
  - owner = FIFO head.
  - r[owner]_recv = m_recv && !empty; the other port's recv is 0.
  - rN_rdata = m_rdata for both ports; rN_error = m_error gated by recv.
  - m_ack = r[owner]_ack when !empty.
  - On m_recv && m_ack && !empty: pop.
- Empty FIFO with m_recv=1: m_ack=1 (drain the response), both recv=0, spurious set until reset.
- Simultaneous push and pop:
  - Both occur; count is unchanged.
  - When full, a pop in the same cycle does not enable a push: full is taken from the registered count.
- Responses are in order: the FIFO pointer wraps modulo OUTSTANDING, and count ranges 0..OUTSTANDING.
- busy = !empty.
- Reset mid-transaction: all tracking is discarded. The external bus must be quiesced by the same reset.

Test Plan:
- r0_req=1 addr=0x1000 wen=0, m_gnt=1 -> r0_gnt=1 same cycle, m_addr=0x1000; m_recv=1 rdata=0xDEADBEEF, r0_ack=1 next cycle -> r0_recv=1, r0_rdata=0xDEADBEEF, FIFO empty.
- r0_req=r1_req=1 held, m_gnt=1 every cycle, responses acked -> grants alternate 0,1,0,1 starting with port 0.
- r1_req=1 with m_gnt=0 for 3 cycles, then r0_req rises -> sel stays 1 (lock) until m_gnt; port 0 is granted on the following contest.
- OUTSTANDING=2, three back-to-back grants with no responses -> third request has m_req=0; one response popped -> third is granted the next cycle.
- Grants to port 1 then port 0; responses 0xA then 0xB with m_error=1 on the second -> r1_recv gets 0xA, r0_recv gets 0xB with r0_error=1.
- m_recv=1 with FIFO empty -> m_ack=1, r0_recv=r1_recv=0, spurious=1 until g_resetn=0.
